// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_res_e;

    // One-hot active-low column drive for column index c.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/keypad_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge detect.
// The step pulse is high for one clk cycle, 3 cycles after the input rises.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    // Synchronize the asynchronous input and register its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame debounce and ghost rejection.
// Optional auto-repeat is compiled in with the KEYPAD_REPEAT_EN macro.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                t_scan,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES);

    logic                              step_s;
    logic [NUM_ROWS-1:0]               rows_meta_q;
    logic [NUM_ROWS-1:0]               rows_sync_q;
    logic [1:0]                        col_q;
    logic [NUM_COLS-1:0]               cols_q;
    logic [NUM_COLS-2:0][NUM_ROWS-1:0] frame_q;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0] press_s;
    logic [4:0]                        hits_s;
    logic [KEY_W-1:0]                  key_s;
    frame_res_e                        res_s;
    logic                              frame_end_s;
    logic                              match_s;
    state_e                            state_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [CNT_W-1:0]                  cnt_inc_s;
    logic [KEY_W-1:0]                  cand_q;
    logic [KEY_W-1:0]                  key_code_q;
    logic                              key_valid_q;
    logic                              key_held_q;

`ifdef KEYPAD_REPEAT_EN
    localparam int              REP_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES);
    logic [REP_W-1:0]           rep_q;
`endif

    sync_edge u_tscan_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (t_scan),
        .rise_o (step_s)
    );

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta_q <= 4'b0000;
            rows_sync_q <= 4'b0000;
        end else begin
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
        end
    end

    // Column pointer and frame storage; column 3 is consumed live at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= 2'd0;
            cols_q  <= 4'b1110;
            frame_q <= '0;
        end else if (step_s) begin
            for (int i = 0; i < NUM_COLS - 1; i++) begin
                if (col_q == 2'(i)) begin
                    frame_q[i] <= ~rows_sync_q;
                end
            end
            col_q  <= col_q + 2'd1;
            cols_q <= col_drive(col_q + 2'd1);
        end
    end

    assign frame_end_s = step_s && (col_q == 2'd3);

    // Classify the completed frame: count pressed intersections, remember the last one.
    always_comb begin
        press_s = {~rows_sync_q, frame_q};
        hits_s  = 5'd0;
        key_s   = 4'd0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (press_s[c][r]) begin
                    hits_s = hits_s + 5'd1;
                    key_s  = KEY_W'(r * NUM_COLS + c);
                end else begin
                    hits_s = hits_s;
                end
            end
        end
        if (hits_s == 5'd0) begin
            res_s = NONE;
        end else if (hits_s == 5'd1) begin
            res_s = SINGLE;
        end else begin
            res_s = MULTI;
        end
    end

    assign match_s   = (res_s == SINGLE) && (key_s == cand_q);
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Debounce/hold FSM; advances only on frame end, outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (frame_end_s) begin
                case (state_q)
                    IDLE: begin
                        if (res_s == SINGLE) begin
                            cand_q <= key_s;
                            if (CNT_LAST == CNT_W'(1)) begin
                                key_code_q  <= key_s;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_q       <= '0;
`endif
                            end else begin
                                cnt_q   <= CNT_W'(1);
                                state_q <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (match_s) begin
                            if (cnt_inc_s == CNT_LAST) begin
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_q       <= '0;
`endif
                            end else begin
                                cnt_q <= cnt_inc_s;
                            end
                        end else begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                    HELD: begin
                        if (match_s) begin
                            cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rep_q + REP_W'(1) == REP_LAST) begin
                                key_valid_q <= 1'b1;
                                rep_q       <= '0;
                            end else begin
                                rep_q <= rep_q + REP_W'(1);
                            end
`endif
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            rep_q <= '0;
`endif
                            if (cnt_inc_s == CNT_LAST) begin
                                key_held_q <= 1'b0;
                                cnt_q      <= '0;
                                state_q    <= IDLE;
                            end else begin
                                cnt_q <= cnt_inc_s;
                            end
                        end
                    end
                    default: begin
                        key_held_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cols      = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan with a behavioural keypad model.
module tb_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic        t_scan;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_REP = 3;
`else
    localparam int EXP_REP = 0;
`endif

    keypad_scan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .t_scan    (t_scan),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key k pulls row k/4 low while column k%4 is driven low.
    function automatic logic [3:0] kp_rows(input logic [15:0] k, input logic [3:0] cdrv);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (k[i] && !cdrv[i % 4]) r[i / 4] = 1'b0;
        end
        return r;
    endfunction

    assign rows = kp_rows(keys, cols);

    // Count every clock cycle in which the strobe is high.
    always @(posedge clk) begin
        if (key_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_step();
        t_scan = 1'b1;
        repeat (8) @(posedge clk);
        t_scan = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int s = 0; s < 4; s++) do_step();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        t_scan = 1'b0;
        keys   = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_cols", int'(cols), 14);
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_held", int'(key_held), 0);
        chk("reset_code", int'(key_code), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_step();
        chk("cols_after_step", int'(cols), 13);
        do_step(); do_step(); do_step();
        chk("cols_wrap", int'(cols), 14);

        // key 9 = row 2, column 1
        keys = 16'h0200;
        do_frames(3);
        chk("k9_no_early_valid", valid_cnt, 0);
        chk("k9_no_early_held", int'(key_held), 0);
        do_frames(1);
        chk("k9_valid_once", valid_cnt, 1);
        chk("k9_code", int'(key_code), 9);
        chk("k9_held", int'(key_held), 1);

        // two-frame release glitch
        keys = 16'h0000;
        do_frames(2);
        keys = 16'h0200;
        do_frames(1);
        chk("glitch_held", int'(key_held), 1);
        chk("glitch_no_valid", valid_cnt, 1);

        // full release
        keys = 16'h0000;
        do_frames(3);
        chk("release_3_held", int'(key_held), 1);
        do_frames(1);
        chk("release_4_held", int'(key_held), 0);

        // bounce: 3 present, 1 absent, then 4 present
        keys = 16'h0200;
        do_frames(3);
        keys = 16'h0000;
        do_frames(1);
        chk("bounce_no_valid", valid_cnt, 1);
        keys = 16'h0200;
        do_frames(3);
        chk("bounce_wait", valid_cnt, 1);
        do_frames(1);
        chk("bounce_valid", valid_cnt, 2);
        chk("bounce_code", int'(key_code), 9);

        // reset in the middle of a scan while a key is held
        do_step(); do_step();
        chk("mid_cols", int'(cols), 11);
        @(negedge clk);
        rst_n = 1'b0;
        keys  = 16'h0000;
        #1;
        chk("mid_reset_cols", int'(cols), 14);
        chk("mid_reset_held", int'(key_held), 0);
        chk("mid_reset_code", int'(key_code), 0);
        chk("mid_reset_valid", int'(key_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ghost: keys 0 and 5 together are rejected
        keys = 16'h0021;
        do_frames(10);
        chk("ghost_no_valid", valid_cnt, 2);
        chk("ghost_no_held", int'(key_held), 0);
        keys = 16'h0000;
        do_frames(1);

        // key 15 (last column, sampled live at frame end)
        keys = 16'h8000;
        do_frames(4);
        chk("k15_valid", valid_cnt, 3);
        chk("k15_code", int'(key_code), 15);
        chk("k15_held", int'(key_held), 1);

        // t_scan frozen: nothing moves even with the key released
        keys = 16'h0000;
        repeat (300) @(negedge clk);
        chk("freeze_held", int'(key_held), 1);
        chk("freeze_cols", int'(cols), 14);
        chk("freeze_valid", valid_cnt, 3);

        // hold 100 frames after acceptance
        keys = 16'h8000;
        do_frames(100);
        chk("repeat_count", valid_cnt, 3 + EXP_REP);
        chk("repeat_code", int'(key_code), 15);
        keys = 16'h0000;
        do_frames(4);
        chk("k15_release", int'(key_held), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
